// File: rtl/de_scoreboard.sv
// de_scoreboard: per-register pending-write counters and decode stall control.
module de_scoreboard #(
  parameter int REGWORDS  = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTBITS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] rs1_DE,
  input  logic                 rs1_read_DE,
  input  logic [REGNOBITS-1:0] rs2_DE,
  input  logic                 rs2_read_DE,
  input  logic [REGNOBITS-1:0] rd_DE,
  input  logic                 wr_reg_DE,
  input  logic                 wr_reg_WB,
  input  logic [REGNOBITS-1:0] wregno_WB,
  input  logic                 cancel_valid,
  input  logic [REGNOBITS-1:0] cancel_rd,
  output logic                 pipeline_stall_DE,
  output logic                 issue_fire,
  output logic [REGWORDS-1:0]  pending_mask,
  output logic [6:0]           inflight_cnt,
  output logic                 sb_err
);
  localparam logic [CNTBITS-1:0] cnt_max = '1;
  logic [CNTBITS-1:0] cnt_q [REGWORDS];
  logic [CNTBITS-1:0] cnt_d [REGWORDS];
  logic [CNTBITS:0]   up    [REGWORDS];
  logic [CNTBITS:0]   dn    [REGWORDS];
  logic [REGWORDS-1:0] mask_q, mask_d;
  logic [6:0] tot_q, tot_d;
  logic err_q, err_d;
  logic busy1, busy2, full_rd;
  // A lone pending write retiring this cycle is readable via the negedge register-file write.
  assign busy1 = rs1_DE != '0 && cnt_q[rs1_DE] != '0 &&
                 !(cnt_q[rs1_DE] == CNTBITS'(1) && wr_reg_WB && wregno_WB == rs1_DE);
  assign busy2 = rs2_DE != '0 && cnt_q[rs2_DE] != '0 &&
                 !(cnt_q[rs2_DE] == CNTBITS'(1) && wr_reg_WB && wregno_WB == rs2_DE);
  assign full_rd = wr_reg_DE && rd_DE != '0 && cnt_q[rd_DE] == cnt_max &&
                   !(wr_reg_WB && wregno_WB == rd_DE);
  assign pipeline_stall_DE = de_valid && ((rs1_read_DE && busy1) || (rs2_read_DE && busy2) || full_rd);
  assign issue_fire = de_valid && !pipeline_stall_DE;
  assign pending_mask = mask_q;
  assign inflight_cnt = tot_q;
  assign sb_err = err_q;
  always_comb begin
    err_d = err_q;
    tot_d = '0;
    mask_d = '0;
    for (int i = 0; i < REGWORDS; i++) begin
      up[i] = {1'b0, cnt_q[i]} + (CNTBITS+1)'(issue_fire && wr_reg_DE && rd_DE == REGNOBITS'(i));
      dn[i] = (CNTBITS+1)'(wr_reg_WB && wregno_WB == REGNOBITS'(i)) +
              (CNTBITS+1)'(cancel_valid && cancel_rd == REGNOBITS'(i));
      cnt_d[i] = (i == 0 || up[i] < dn[i]) ? '0 : CNTBITS'(up[i] - dn[i]);
      err_d = err_d | (i != 0 && up[i] < dn[i]);
      mask_d[i] = cnt_d[i] != '0;
      tot_d = tot_d + 7'(cnt_d[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGWORDS; i++) cnt_q[i] <= '0;
      mask_q <= '0;
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/de_scoreboard.md
# de_scoreboard

Per-register pending-write scoreboard and stall controller for the decode stage. It tracks how many in-flight instructions (AGEX, MEM, WB) will write each architectural register. It raises the decode stall to the fetch stage when the instruction in decode reads a register with an outstanding write that is not retiring this cycle. It replaces destination-ID comparison against every downstream stage with a single counted, cycle-accurate resource tracker.

## Interface
Parameters:
- REGWORDS, 32, number of architectural registers; register 0 is never tracked.
- REGNOBITS, 5, register ID width.
- CNTBITS, 2, per-register pending counter width; maximum count is 2^CNTBITS-1.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- de_valid  in  1  decode holds a real (non-bubble) instruction.
- rs1_DE  in  REGNOBITS  first source register ID.
- rs1_read_DE  in  1  instruction reads rs1.
- rs2_DE  in  REGNOBITS  second source register ID.
- rs2_read_DE  in  1  instruction reads rs2.
- rd_DE  in  REGNOBITS  destination register ID.
- wr_reg_DE  in  1  instruction writes rd.
- wr_reg_WB  in  1  writeback commits a register write this cycle.
- wregno_WB  in  REGNOBITS  writeback destination ID.
- cancel_valid  in  1  a previously issued writer was squashed and will never reach WB.
- cancel_rd  in  REGNOBITS  destination ID of the squashed writer.
- pipeline_stall_DE  out  1  combinational stall to fetch and decode latch.
- issue_fire  out  1  combinational; decode instruction advances this cycle.
- pending_mask  out  REGWORDS  registered; bit i = count[i] != 0.
- inflight_cnt  out  7  registered total of all per-register counts.
- sb_err  out  1  registered, sticky underflow error flag.

## Operation
- State: count[i] for i = 1..REGWORDS-1, CNTBITS wide; count[0] is hardwired 0.
- retire_hit(r) = wr_reg_WB && wregno_WB == r && r != 0.
- src_busy(r) = r != 0 && count[r] != 0 && !(count[r] == 1 && retire_hit(r)).
  - A single pending write retiring this cycle is not a hazard. The register file writes on negedge, so the value is readable before the next posedge.
- full_rd = wr_reg_DE && rd_DE != 0 && count[rd_DE] == max && !retire_hit(rd_DE).
- pipeline_stall_DE = de_valid && ((rs1_read_DE && src_busy(rs1_DE)) || (rs2_read_DE && src_busy(rs2_DE)) || full_rd).
- issue_fire = de_valid && !pipeline_stall_DE.
- inc(r) = issue_fire && wr_reg_DE && rd_DE == r.
- dec(r) = retire_hit(r) + (cancel_valid && cancel_rd == r). Each source contributes 1.
- Next count[r] = count[r] + inc(r) - dec(r), for r != 0.
  - Computed with one bit of extra width.
  - A negative result clamps to 0 and sets sb_err.
  - A result above max cannot occur, because full_rd prevents it.
- IDs equal to 0 on issue, retire or cancel are ignored entirely, with no error.
- inflight_cnt next = sum of next counts. pending_mask next = OR-reduction per next count.
- sb_err is sticky; it clears only on reset.

## Timing
- Reset: on posedge with reset=1, all counts, pending_mask, inflight_cnt and sb_err go to 0. This overrides any same-cycle issue, retire or cancel.
  - Combinational outputs then follow the zeroed state: stall=0 and issue_fire=de_valid.
- Stall and issue_fire have zero-cycle latency from inputs and current state.
- Count updates are visible on the cycle after the posedge.
- Back-to-back dependent pair: the consumer stalls from the cycle after producer issue until the producer's WB cycle. In the WB cycle the stall drops and the consumer issues.
- Simultaneous issue, retire and cancel on the same register net algebraically in one cycle.
- The instruction stalled in decode is never counted. It counts only in the cycle issue_fire=1.

## Test plan
- Reset, then de_valid=1, rs1=5 read, rd=5 write, no WB:
  - stall=0, issue_fire=1.
  - Next cycle count[5]=1, pending_mask=0x20, inflight_cnt=1.
- RAW hazard: issue writer of x7, then consumer reading x7. WB arrives 3 cycles later:
  - stall=1 for 2 cycles, drops in the WB cycle, consumer issues.
  - count[7] returns to 0.
- Saturation: issue three writers of x3 with no WB, then a fourth writer of x3:
  - Fourth is stalled (full_rd).
  - If a WB of x3 arrives in that same cycle, it issues instead and count stays 3.
- Same cycle: issue rd=9, WB of x9 and cancel of x9 with count[9]=2:
  - Next count[9]=1, sb_err=0.
- Underflow: cancel_rd=4 with count[4]=0:
  - count[4] stays 0, sb_err=1 and remains set until reset.
  - x0 cancel/WB/issue has no effect and no error.
- Mid-operation reset with inflight_cnt=5 and a simultaneous issue:
  - Next cycle all counts 0, pending_mask=0, inflight_cnt=0, sb_err=0.
